// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its pending scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_AW = clog2(DEF_NREG);

endpackage

// File: rtl/regfile_pending.sv
// Per-register pending bits set by load issue and cleared by load writeback,
// with a registered population count.
module regfile_pending
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int ZERO_R0 = 1,
  localparam int AW = clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] pend,
  output logic [AW:0]     cnt
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            set_ok, up, down;

  // Set is applied after clear so a new load issued in the same cycle wins.
  always_comb begin
    set_ok = set_en && !((ZERO_R0 != 0) && (set_addr == '0));
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_ok) pend_d[set_addr] = 1'b1;
    up   = set_ok && !pend_q[set_addr];
    down = clr_en && pend_q[clr_addr] && !(set_ok && (set_addr == clr_addr));
    cnt_d = cnt_q;
    if (up && !down)      cnt_d = cnt_q + ONE;
    else if (down && !up) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend = pend_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/regfile_scb.sv
// Dual-write register file with write-first read bypass, optional zero register
// and a load-pending scoreboard for issue-time busy checks.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend;
  logic [AW-1:0]   rd_a [NRD];
  logic            wa_ok, wb_ok;

  assign wa_ok = wa_en && !((ZERO_R0 != 0) && (wa_addr == '0));
  assign wb_ok = wb_en && !((ZERO_R0 != 0) && (wb_addr == '0));

  // Port B is applied last so it wins a same-address collision with port A.
  always_comb begin
    regs_d = regs_q;
    if (wa_ok) regs_d[wa_addr] = wa_data;
    if (wb_ok) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  regfile_pending #(
    .NREG    (NREG),
    .ZERO_R0 (ZERO_R0)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .pend     (pend),
    .cnt      (pend_cnt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_addr
    assign rd_a[g] = rd_addr[g*AW +: AW];
  end

  // Bypass order mirrors write priority; a resolving writeback hides busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!rst && !((ZERO_R0 != 0) && (rd_a[i] == '0))) begin
        if (wb_en && (wb_addr == rd_a[i]))      rd_data[i*XLEN +: XLEN] = wb_data;
        else if (wa_en && (wa_addr == rd_a[i])) rd_data[i*XLEN +: XLEN] = wa_data;
        else                                    rd_data[i*XLEN +: XLEN] = regs_q[rd_a[i]];
        rd_busy[i] = pend[rd_a[i]] && !(wb_en && (wb_addr == rd_a[i]));
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!rst && !((ZERO_R0 != 0) && (dbg_addr == '0))) dbg_data = regs_q[dbg_addr];
  end

endmodule
